// File: rtl/data_sram_responder_if.sv
// Data SRAM request/response bus between the core's EX/MEM stages and the responder.
// Signal names follow the core's data_sram_* port naming.
interface data_sram_responder_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/data_sram_responder.sv
// Single-port byte-writable word RAM fronted by an in-order store buffer.
// Reads are single-cycle with per-byte forwarding; stores drain on any non-read cycle.
module data_sram_responder #(
  parameter int ADDR_W   = 16,
  parameter int SB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        resetn,
  data_sram_responder_if.slave        bus,
  output logic [$clog2(SB_DEPTH):0]   sb_count,
  output logic                        sb_empty
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]       mem_q [2**ADDR_W];
  logic [31:0]       ram_rd_q;

  logic [ADDR_W-1:0] sb_idx_q  [SB_DEPTH];
  logic [3:0]        sb_we_q   [SB_DEPTH];
  logic [31:0]       sb_data_q [SB_DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              empty_q, empty_d;
  logic [3:0]        fwd_mask_q, fwd_mask_d;
  logic [31:0]       fwd_data_q, fwd_data_d;

  logic [ADDR_W-1:0] req_idx;
  logic              is_read;
  logic              is_write;
  logic              drain;
  logic              unused_addr;

  assign req_idx     = bus.data_sram_addr[ADDR_W+1:2];
  assign unused_addr = ^{bus.data_sram_addr[31:ADDR_W+2], bus.data_sram_addr[1:0]};
  assign is_read     = bus.data_sram_en && (bus.data_sram_we == 4'b0000);
  assign is_write    = bus.data_sram_en && (bus.data_sram_we != 4'b0000);
  assign drain       = !is_read && (count_q != '0);

  // Scan oldest to youngest so later entries overwrite earlier ones per lane.
  always_comb begin
    logic [PTR_W-1:0] slot;
    slot       = '0;
    fwd_mask_d = '0;
    fwd_data_d = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      slot = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (sb_idx_q[slot] == req_idx)) begin
        for (int b = 0; b < 4; b++) begin
          if (sb_we_q[slot][b]) begin
            fwd_mask_d[b]        = 1'b1;
            fwd_data_d[b*8 +: 8] = sb_data_q[slot][b*8 +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    head_d  = head_q + PTR_W'(drain);
    tail_d  = tail_q + PTR_W'(is_write);
    count_d = count_q + CNT_W'(is_write) - CNT_W'(drain);
    empty_d = (count_d == '0);
  end

  // Reset forces every lane onto the zeroed forward register so rdata reads 0
  // without needing to reset the RAM output register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      fwd_mask_q <= 4'hF;
      fwd_data_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      empty_q <= empty_d;
      if (is_read) begin
        fwd_mask_q <= fwd_mask_d;
        fwd_data_q <= fwd_data_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (is_write) begin
      sb_idx_q[tail_q]  <= req_idx;
      sb_we_q[tail_q]   <= bus.data_sram_we;
      sb_data_q[tail_q] <= bus.data_sram_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (is_read) begin
      ram_rd_q <= mem_q[req_idx];
    end
    if (drain) begin
      for (int b = 0; b < 4; b++) begin
        if (sb_we_q[head_q][b]) begin
          mem_q[sb_idx_q[head_q]][b*8 +: 8] <= sb_data_q[head_q][b*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    bus.data_sram_rdata = '0;
    for (int b = 0; b < 4; b++) begin
      bus.data_sram_rdata[b*8 +: 8] = fwd_mask_q[b] ? fwd_data_q[b*8 +: 8]
                                                    : ram_rd_q[b*8 +: 8];
    end
  end

  assign sb_count = count_q;
  assign sb_empty = empty_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder with a queue/associative-array reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_data_sram_responder;

  logic       clk;
  logic       resetn;
  logic [2:0] sb_count;
  logic       sb_empty;

  data_sram_responder_if bus ();

  data_sram_responder #(.ADDR_W(16), .SB_DEPTH(4)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus.slave),
    .sb_count (sb_count),
    .sb_empty (sb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a FIFO of pending stores and a byte-known word memory.
  typedef struct {
    int        idx;
    bit [3:0]  we;
    bit [31:0] data;
  } ent_t;

  ent_t      q_m[$];
  bit [31:0] ram_m [int];
  bit [3:0]  kn_m  [int];
  bit [31:0] exp_rdata = 32'h0;
  bit        exp_known = 1'b1;
  int        exp_count = 0;
  bit        cmp_en    = 1'b0;

  always @(negedge resetn) begin
    q_m.delete();
    exp_rdata = 32'h0;
    exp_known = 1'b1;
    exp_count = 0;
  end

  always @(posedge clk) begin
    if (resetn) begin
      int        w;
      bit [31:0] v;
      bit [3:0]  k;
      ent_t      e;
      w = int'(bus.data_sram_addr[17:2]);
      if (bus.data_sram_en && bus.data_sram_we == 4'b0000) begin
        v = ram_m.exists(w) ? ram_m[w] : 32'h0;
        k = kn_m.exists(w) ? kn_m[w] : 4'h0;
        foreach (q_m[i]) begin
          if (q_m[i].idx == w) begin
            for (int b = 0; b < 4; b++) begin
              if (q_m[i].we[b]) begin
                v[b*8 +: 8] = q_m[i].data[b*8 +: 8];
                k[b] = 1'b1;
              end
            end
          end
        end
        exp_rdata = v;
        exp_known = (k == 4'hF);
      end else if (q_m.size() > 0) begin
        e = q_m.pop_front();
        v = ram_m.exists(e.idx) ? ram_m[e.idx] : 32'h0;
        k = kn_m.exists(e.idx) ? kn_m[e.idx] : 4'h0;
        for (int b = 0; b < 4; b++) begin
          if (e.we[b]) begin
            v[b*8 +: 8] = e.data[b*8 +: 8];
            k[b] = 1'b1;
          end
        end
        ram_m[e.idx] = v;
        kn_m[e.idx]  = k;
      end
      if (bus.data_sram_en && bus.data_sram_we != 4'b0000) begin
        e.idx  = w;
        e.we   = bus.data_sram_we;
        e.data = bus.data_sram_wdata;
        q_m.push_back(e);
      end
      exp_count = q_m.size();
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_sb_count", {29'h0, sb_count}, exp_count);
      chk("model_sb_empty", {31'h0, sb_empty}, {31'h0, exp_count == 0});
      if (exp_known) chk("model_rdata", bus.data_sram_rdata, exp_rdata);
    end
  end

  task automatic req(input bit en, input bit [3:0] we, input bit [31:0] addr,
                     input bit [31:0] wdata);
    bus.data_sram_en    = en;
    bus.data_sram_we    = we;
    bus.data_sram_addr  = addr;
    bus.data_sram_wdata = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit [3:0] we, input bit [31:0] addr, input bit [31:0] d);
    req(1'b1, we, addr, d);
  endtask

  task automatic rd(input bit [31:0] addr);
    req(1'b1, 4'h0, addr, 32'h0);
  endtask

  task automatic idle();
    req(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    resetn              = 1'b0;
    bus.data_sram_en    = 1'b0;
    bus.data_sram_we    = 4'h0;
    bus.data_sram_addr  = 32'h0;
    bus.data_sram_wdata = 32'h0;
    #11;
    chk("reset_count", {29'h0, sb_count}, 32'd0);
    chk("reset_empty", {31'h0, sb_empty}, 32'd1);
    chk("reset_rdata", bus.data_sram_rdata, 32'h0);
    #1;
    resetn = 1'b1;
    cmp_en = 1'b1;

    // write then read, forwarded from the buffer
    wr(4'hF, 32'h100, 32'hDEADBEEF);
    chk("wr_count", {29'h0, sb_count}, 32'd1);
    rd(32'h100);
    chk("fwd_full_word", bus.data_sram_rdata, 32'hDEADBEEF);
    idle();

    // byte merge of RAM word with a partially drained pair of stores
    wr(4'hF, 32'h40, 32'h11223344);
    idle();
    wr(4'b0001, 32'h40, 32'hAAAAAAAA);
    wr(4'b0100, 32'h40, 32'hBBBBBBBB);
    rd(32'h40);
    chk("byte_merge", bus.data_sram_rdata, 32'h11BB33AA);
    idle();

    // youngest store wins per lane
    wr(4'hF, 32'h80, 32'h01010101);
    wr(4'b0011, 32'h80, 32'h02020202);
    rd(32'h80);
    chk("youngest_wins", bus.data_sram_rdata, 32'h01010202);
    idle();

    // back-to-back writes drain every cycle after the first
    for (int i = 0; i < 6; i++) begin
      wr(4'hF, i * 4, i);
      chk("b2b_count", {29'h0, sb_count}, 32'd1);
    end
    idle();
    chk("b2b_drained", {29'h0, sb_count}, 32'd0);
    chk("b2b_empty", {31'h0, sb_empty}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      rd(i * 4);
      chk("b2b_readback", bus.data_sram_rdata, i);
    end

    // addresses differing above the word-index range alias
    wr(4'hF, 32'h0004_0100, 32'hCAFEF00D);
    rd(32'h100);
    chk("alias_fwd", bus.data_sram_rdata, 32'hCAFEF00D);
    idle();
    rd(32'h8000_0103);
    chk("alias_ram", bus.data_sram_rdata, 32'hCAFEF00D);

    // reads hold off draining
    wr(4'hF, 32'h600, 32'h00000066);
    idle();
    wr(4'hF, 32'h500, 32'h500);
    wr(4'hF, 32'h504, 32'h504);
    wr(4'hF, 32'h508, 32'h508);
    for (int i = 0; i < 5; i++) begin
      rd(32'h600);
      chk("rdblk_count", {29'h0, sb_count}, 32'd1);
      chk("rdblk_rdata", bus.data_sram_rdata, 32'h66);
    end
    idle();
    chk("rdblk_drain", {29'h0, sb_count}, 32'd0);
    idle();
    chk("rdata_hold", bus.data_sram_rdata, 32'h66);
    rd(32'h508);
    chk("rdblk_readback", bus.data_sram_rdata, 32'h508);

    // async reset discards the pending store
    wr(4'hF, 32'h200, 32'hA1);
    wr(4'hF, 32'h204, 32'hB2);
    wr(4'hF, 32'h208, 32'hC3);
    idle();
    wr(4'hF, 32'h200, 32'hA9);
    wr(4'hF, 32'h204, 32'hB9);
    wr(4'hF, 32'h208, 32'hC9);
    chk("pre_reset_count", {29'h0, sb_count}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_reset_count", {29'h0, sb_count}, 32'd0);
    chk("mid_reset_empty", {31'h0, sb_empty}, 32'd1);
    chk("mid_reset_rdata", bus.data_sram_rdata, 32'h0);
    #3;
    resetn = 1'b1;
    rd(32'h208);
    chk("reset_discard", bus.data_sram_rdata, 32'hC3);
    rd(32'h200);
    chk("reset_kept0", bus.data_sram_rdata, 32'hA9);
    rd(32'h204);
    chk("reset_kept1", bus.data_sram_rdata, 32'hB9);
    idle();
    idle();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
